blocpu_program_dumper: RTL and testbench
========================================

BLOCPU_PROGRAM_DUMPER -- requirements
Module: blocpu_program_dumper

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, which is the clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, which is the UART bit rate; BAUD_DIV = CLK_HZ/BAUD (integer division, at least 2).
REQ-003 SHALL have port CLK  input  1  the single clock; all logic is on posedge CLK.
REQ-004 SHALL have port in_reset  input  1  synchronous active-high reset.
REQ-005 SHALL have port in_start  input  1  request to start a dump; sampled when idle.
REQ-006 SHALL have port in_first_address  input  16  program-memory address of the first instruction, captured at start.
REQ-007 SHALL have port in_count  input  16  number of instructions to dump, captured at start.
REQ-008 SHALL have port out_mem_address  output  16  read address to program memory.
REQ-009 SHALL have port in_mem_instruction  input  12  read data, valid exactly 1 cycle after out_mem_address is presented.
REQ-010 SHALL have port TxD  output  1  UART serial out, 8N1, LSB first, idle high.
REQ-011 SHALL have port out_busy  output  1  high while a dump is in progress.
REQ-012 SHALL have port out_done  output  1  one-cycle pulse when a dump completes.

Function
REQ-013 SHALL serialise each instruction as 2 bytes, high byte first: {4'b0000, instr[11:8]}, then instr[7:0].
REQ-014 SHALL run a controller with states IDLE -> FETCH -> LATCH -> SEND_HI -> SEND_LO -> (FETCH | FINISH) -> IDLE.
REQ-015 SHALL accept in_start only in IDLE; in_start during any other state is ignored and not queued.
REQ-016 SHALL, on accepted start with in_count=0, pulse out_done on the next cycle, keep out_busy low, and leave TxD high.
REQ-017 SHALL, on accepted start with in_count>0, assert out_busy from the next cycle until out_done.
REQ-018 SHALL ensure the first start bit begins no more than 3 cycles after start acceptance.
REQ-019 SHALL present the address in FETCH and capture in_mem_instruction in LATCH, exactly 1 cycle later.
REQ-020 SHALL increment the address by 1 per instruction modulo 2^16 (0xFFFF wraps to 0x0000).
REQ-021 SHALL hold every UART bit (start, 8 data, stop) for exactly BAUD_DIV cycles.
REQ-022 SHALL leave no more than 3 idle-high cycles between consecutive bytes within a dump.
REQ-023 SHALL keep out_mem_address stable while a byte is transmitting.
REQ-024 SHALL, after the final stop bit completes, pulse out_done for 1 cycle and drop out_busy in that same cycle.
REQ-025 SHALL keep TxD high in IDLE and FINISH.

Reset
REQ-026 SHALL, when in_reset=1 at a posedge, go to IDLE with TxD=1, out_busy=0, out_done=0, out_mem_address=0, and the baud and bit counters cleared.
REQ-027 SHALL treat reset mid-byte by abandoning the frame: TxD is high on the next cycle, no out_done is produced, and in_start is accepted from the first cycle after reset is released.

Structure
REQ-028 SHALL place the state encoding, the 12-bit instruction width, and the 16-bit address width in the shared blocpu package.
REQ-029 SHALL instantiate one sub-module, blocpu_uart_tx: byte in, start strobe in, busy out, TxD out, parameter BAUD_DIV.

Verification
REQ-030 SHALL use a bench with CLK_HZ=16 and BAUD=1 (BAUD_DIV=16) and a 1-cycle-latency memory model; every check below is made at bit centres.
REQ-031 SHALL test: mem[0]=0x800, start with first=0, count=1 -> TxD bytes 0x08,0x00; out_done pulses once; out_busy then low.
REQ-032 SHALL test: mem[9..11]=0xEFF,0xFFF,0x306, start with first=9, count=3 -> bytes 0E FF 0F FF 03 06; each bit exactly 16 cycles.
REQ-033 SHALL test: count=0 -> out_done on the next cycle; out_busy never high; TxD constant 1.
REQ-034 SHALL test: first=0xFFFF, count=2 -> addresses 0xFFFF then 0x0000 are read, and both instructions are transmitted.
REQ-035 SHALL test: in_start pulsed mid-dump -> ignored; the byte count is unchanged.
REQ-036 SHALL test: in_reset mid-bit of the second byte -> TxD=1 and out_busy=0 on the next cycle with no out_done; a new start then dumps correctly.

Source files
------------

// File: rtl/blocpu_pkg.sv
// Shared definitions for the blocpu program dumper: controller state encoding,
// instruction and address widths, and the high-byte framing helper.
package blocpu_pkg;

  localparam int unsigned InstrWidth = 12;
  localparam int unsigned AddrWidth  = 16;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLatch,
    StSendHi,
    StSendLo,
    StFinish
  } state_e;

  // High byte on the wire carries the top nibble of the 12-bit instruction.
  function automatic logic [7:0] hi_byte(input logic [InstrWidth-1:0] instr);
    return {4'b0000, instr[InstrWidth-1:8]};
  endfunction

endpackage

// File: rtl/blocpu_uart_tx.sv
// 8N1 UART transmitter, LSB first, idle high.
// Ports:
//   clk_i   - clock
//   rst_i   - synchronous active-high reset; abandons any frame in flight
//   start_i - load byte_i and begin a frame (ignored while busy)
//   byte_i  - byte to send
//   busy_o  - high from the cycle after start until the stop bit completes
//   txd_o   - serial output
module blocpu_uart_tx #(
  parameter int unsigned BAUD_DIV = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [7:0] byte_i,
  output logic       busy_o,
  output logic       txd_o
);

  localparam int unsigned    CntW   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(BAUD_DIV - 1);

  logic [9:0]      shift_q, shift_d;
  logic [3:0]      bit_q, bit_d;
  logic [CntW-1:0] baud_q, baud_d;
  logic            busy_q, busy_d;

  always_comb begin
    shift_d = shift_q;
    bit_d   = bit_q;
    baud_d  = baud_q;
    busy_d  = busy_q;
    if (!busy_q) begin
      if (start_i) begin
        // Frame is {stop, data, start}; bit 0 is driven first.
        shift_d = {1'b1, byte_i, 1'b0};
        bit_d   = 4'd0;
        baud_d  = '0;
        busy_d  = 1'b1;
      end
    end else if (baud_q == CntMax) begin
      baud_d = '0;
      if (bit_q == 4'd9) begin
        busy_d = 1'b0;
      end else begin
        shift_d = {1'b1, shift_q[9:1]};
        bit_d   = bit_q + 4'd1;
      end
    end else begin
      baud_d = baud_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shift_q <= '1;
      bit_q   <= '0;
      baud_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      shift_q <= shift_d;
      bit_q   <= bit_d;
      baud_q  <= baud_d;
      busy_q  <= busy_d;
    end
  end

  assign busy_o = busy_q;
  assign txd_o  = busy_q ? shift_q[0] : 1'b1;

endmodule

// File: rtl/blocpu_program_dumper.sv
// Dumps a range of program memory over a UART, two bytes per instruction,
// high byte ({4'b0, instr[11:8]}) first.
// Ports:
//   CLK                - clock
//   in_reset           - synchronous active-high reset
//   in_start           - start request, honoured only when idle
//   in_first_address   - first instruction address, captured at start
//   in_count           - instruction count, captured at start
//   out_mem_address    - program memory read address
//   in_mem_instruction - read data, one cycle after the address
//   TxD                - UART serial output
//   out_busy           - dump in progress
//   out_done           - one-cycle completion pulse
module blocpu_program_dumper
  import blocpu_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50000000,
  parameter int unsigned BAUD   = 115200
) (
  input  logic                  CLK,
  input  logic                  in_reset,
  input  logic                  in_start,
  input  logic [AddrWidth-1:0]  in_first_address,
  input  logic [15:0]           in_count,
  output logic [AddrWidth-1:0]  out_mem_address,
  input  logic [InstrWidth-1:0] in_mem_instruction,
  output logic                  TxD,
  output logic                  out_busy,
  output logic                  out_done
);

  localparam int unsigned BAUD_DIV = CLK_HZ / BAUD;

  state_e                state_q, state_d;
  logic [AddrWidth-1:0]  addr_q, addr_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [InstrWidth-1:0] instr_q, instr_d;

  logic       tx_start;
  logic [7:0] tx_byte;
  logic       tx_busy;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    instr_d  = instr_q;
    tx_start = 1'b0;
    tx_byte  = 8'h00;
    out_busy = 1'b1;
    out_done = 1'b0;
    unique case (state_q)
      StIdle: begin
        out_busy = 1'b0;
        if (in_start) begin
          addr_d  = in_first_address;
          cnt_d   = in_count;
          state_d = (in_count == 16'd0) ? StFinish : StFetch;
        end
      end
      StFetch: state_d = StLatch;
      StLatch: begin
        // Launch the high byte straight off the memory data to save a cycle.
        instr_d  = in_mem_instruction;
        tx_byte  = hi_byte(in_mem_instruction);
        tx_start = 1'b1;
        state_d  = StSendHi;
      end
      StSendHi: begin
        if (!tx_busy) begin
          tx_byte  = instr_q[7:0];
          tx_start = 1'b1;
          state_d  = StSendLo;
        end
      end
      StSendLo: begin
        // Address only moves once the low byte is fully out.
        if (!tx_busy) begin
          if (cnt_q == 16'd1) begin
            state_d = StFinish;
          end else begin
            cnt_d   = cnt_q - 16'd1;
            addr_d  = addr_q + 16'd1;
            state_d = StFetch;
          end
        end
      end
      StFinish: begin
        out_busy = 1'b0;
        out_done = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (in_reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      cnt_q   <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
    end
  end

  assign out_mem_address = addr_q;

  blocpu_uart_tx #(
    .BAUD_DIV(BAUD_DIV)
  ) u_uart_tx (
    .clk_i  (CLK),
    .rst_i  (in_reset),
    .start_i(tx_start),
    .byte_i (tx_byte),
    .busy_o (tx_busy),
    .txd_o  (TxD)
  );

endmodule

// File: tb/tb_blocpu_program_dumper.sv
// Scoreboard bench for blocpu_program_dumper at 16 cycles per UART bit.
module tb_blocpu_program_dumper;

  logic        CLK = 1'b0;
  logic        in_reset, in_start;
  logic [15:0] in_first_address, in_count, out_mem_address;
  logic [11:0] in_mem_instruction;
  logic        TxD, out_busy, out_done;

  always #5 CLK = ~CLK;

  blocpu_program_dumper #(
    .CLK_HZ(16),
    .BAUD  (1)
  ) dut (
    .CLK               (CLK),
    .in_reset          (in_reset),
    .in_start          (in_start),
    .in_first_address  (in_first_address),
    .in_count          (in_count),
    .out_mem_address   (out_mem_address),
    .in_mem_instruction(in_mem_instruction),
    .TxD               (TxD),
    .out_busy          (out_busy),
    .out_done          (out_done)
  );

  // Program memory with one cycle of read latency.
  logic [11:0] mem [0:65535];
  always @(posedge CLK) in_mem_instruction <= mem[out_mem_address];

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } exp_t;
  exp_t exp_q[$];

  int n_cmp  = 0;
  int n_fail = 0;
  int done_cnt = 0;

  always @(negedge CLK) if (out_done === 1'b1) done_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_le(input string name, input int act, input int lim);
    n_cmp++;
    if (act > lim) begin
      n_fail++;
      $display("FAIL %s: got %0d, required <= %0d", name, act, lim);
    end
  endtask

  // Monitor: decodes every frame from TxD at bit centres and checks bit timing.
  initial begin : monitor
    logic        smp [160];
    logic [7:0]  got;
    logic [15:0] got_addr;
    bit          aborted, gap_trk, timing_ok;
    int          gap;
    exp_t        e;
    gap_trk = 0;
    gap     = 0;
    forever begin
      @(negedge CLK);
      if (in_reset === 1'b1) begin
        gap_trk = 0;
      end else if (TxD === 1'b0) begin
        if (gap_trk) chk_le("byte_gap", gap, 3);
        gap_trk  = 0;
        smp[0]   = 1'b0;
        aborted  = 0;
        got_addr = out_mem_address;
        for (int i = 1; i < 160; i++) begin
          @(negedge CLK);
          if (in_reset === 1'b1) begin
            aborted = 1;
            break;
          end
          smp[i] = TxD;
          if (i == 8) got_addr = out_mem_address;
        end
        if (!aborted) begin
          timing_ok = 1;
          for (int b = 0; b < 10; b++)
            for (int c = 0; c < 16; c++)
              if (smp[b*16+c] !== smp[b*16+8]) timing_ok = 0;
          chk("bit_timing", 32'(timing_ok), 1);
          chk("stop_bit", 32'(smp[152]), 1);
          for (int b = 0; b < 8; b++) got[b] = smp[(b+1)*16+8];
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_byte: got %02h, expected no byte", got);
          end else begin
            e = exp_q.pop_front();
            chk("byte_data", 32'(got), 32'(e.data));
            chk("byte_addr", 32'(got_addr), 32'(e.addr));
          end
          gap_trk = 1;
          gap     = 0;
        end
      end else if (gap_trk) begin
        if (out_busy === 1'b1) gap++;
        else gap_trk = 0;
      end
    end
  end

  // Caller must be at a negedge. Pushes the expected bytes, pulses in_start.
  task automatic start_dump(input logic [15:0] first, input logic [15:0] count,
                            output int d0);
    logic [15:0] a;
    int          k;
    bit          quiet;
    d0 = done_cnt;
    in_first_address = first;
    in_count         = count;
    in_start         = 1'b1;
    for (int i = 0; i < int'(count); i++) begin
      a = first + 16'(i);
      exp_q.push_back('{addr: a, data: {4'b0000, mem[a][11:8]}});
      exp_q.push_back('{addr: a, data: mem[a][7:0]});
    end
    @(negedge CLK);
    in_start = 1'b0;
    if (count == 16'd0) begin
      chk("zero_done", 32'(out_done), 1);
      chk("zero_busy", 32'(out_busy), 0);
      quiet = 1;
      repeat (40) begin
        @(negedge CLK);
        if (TxD !== 1'b1 || out_busy !== 1'b0 || out_done !== 1'b0) quiet = 0;
      end
      chk("zero_quiet", 32'(quiet), 1);
    end else begin
      chk("busy_rise", 32'(out_busy), 1);
      k = 1;
      while (TxD !== 1'b0 && k < 10) begin
        @(negedge CLK);
        k++;
      end
      chk_le("start_latency", k - 1, 3);
    end
  endtask

  task automatic finish_dump(input int count, input bit mid, input int d0);
    int k;
    int bound;
    if (mid) begin
      repeat (150) @(negedge CLK);
      in_start         = 1'b1;
      in_first_address = 16'($urandom);
      in_count         = 16'd5;
      @(negedge CLK);
      in_start = 1'b0;
    end
    k     = 0;
    bound = count * 400 + 100;
    while (out_done !== 1'b1 && k < bound) begin
      @(negedge CLK);
      k++;
    end
    chk("done_seen", 32'(out_done), 1);
    chk("busy_at_done", 32'(out_busy), 0);
    repeat (20) @(negedge CLK);
    chk("busy_after", 32'(out_busy), 0);
    chk("done_pulses", 32'(done_cnt - d0), 1);
    chk("bytes_left", 32'(exp_q.size()), 0);
  endtask

  task automatic run_dump(input logic [15:0] first, input logic [15:0] count, input bit mid);
    int d0;
    @(negedge CLK);
    start_dump(first, count, d0);
    if (count != 16'd0) finish_dump(int'(count), mid, d0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : main
    int d0, d1;
    in_reset         = 1'b1;
    in_start         = 1'b0;
    in_first_address = '0;
    in_count         = '0;
    for (int i = 0; i < 65536; i++) mem[i] = 12'($urandom);
    repeat (3) @(negedge CLK);
    chk("rst_txd", 32'(TxD), 1);
    chk("rst_busy", 32'(out_busy), 0);
    chk("rst_done", 32'(out_done), 0);
    chk("rst_addr", 32'(out_mem_address), 0);
    in_reset = 1'b0;

    mem[0] = 12'h800;
    run_dump(16'd0, 16'd1, 1'b0);

    mem[9]  = 12'hEFF;
    mem[10] = 12'hFFF;
    mem[11] = 12'h306;
    run_dump(16'd9, 16'd3, 1'b0);

    run_dump(16'h1234, 16'd0, 1'b0);

    run_dump(16'hFFFF, 16'd2, 1'b0);

    run_dump(16'($urandom), 16'd3, 1'b1);

    repeat (4) run_dump(16'($urandom), 16'($urandom_range(1, 3)), 1'b0);

    // Reset in the middle of the second byte.
    @(negedge CLK);
    start_dump(16'($urandom), 16'd2, d0);
    repeat (233) @(negedge CLK);
    chk("pre_rst_busy", 32'(out_busy), 1);
    d1       = done_cnt;
    in_reset = 1'b1;
    @(negedge CLK);
    chk("mid_rst_txd", 32'(TxD), 1);
    chk("mid_rst_busy", 32'(out_busy), 0);
    chk("mid_rst_done", 32'(out_done), 0);
    chk("mid_rst_addr", 32'(out_mem_address), 0);
    @(negedge CLK);
    in_reset = 1'b0;
    exp_q.delete();
    chk("mid_rst_no_done", 32'(done_cnt - d1), 0);
    start_dump(16'($urandom), 16'd2, d0);
    finish_dump(2, 1'b0, d0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
